// File: rtl/loopback_channel.sv
// Purpose : baseband channel emulator; it loops Tx DAC samples back to the Rx ADC side and applies delay, rotation, gain, noise and DC.
// Latency : 3 + CH_DELAY cycles from DAC_* to ADC_* (S0 delay-line read, S1 rotate+gain, S2 noise+DC+saturate).
// Backpres: none. The channel accepts one sample per cycle, and ADC_vld simply follows the delayed DAC_vld.
//
// Ports:
//   clk_16M384, rst_16M384     single clock and synchronous active-high reset
//   DAC_I/DAC_Q/DAC_vld        Tx samples (signed, DW bits) and their valid strobe
//   CH_ROT                     phase rotation 0/90/180/270 degrees
//   CH_GAIN                    gain numerator over 4 (0..15)
//   CH_DELAY                   extra delay in samples (0..MAX_DELAY-1)
//   CH_NOISE_AMP               noise bits per rail (clamped to NOISE_W)
//   CH_DC                      signed DC offset added to both rails
//   CH_SEED                    LFSR seed loaded at reset (0 selects 16'hACE1)
//   SAT_CLR                    clears the sticky SAT_FLAG
//   ADC_I/ADC_Q/ADC_vld        Rx samples; both rails are 0 whenever ADC_vld is 0
//   SAT_FLAG                   sticky flag, set when any rail of a valid sample clips
module loopback_channel #(
    parameter int DW        = 12,
    parameter int MAX_DELAY = 16,
    parameter int NOISE_W   = 8
) (
    input  logic                         clk_16M384,
    input  logic                         rst_16M384,
    input  logic signed [DW-1:0]         DAC_I,
    input  logic signed [DW-1:0]         DAC_Q,
    input  logic                         DAC_vld,
    input  logic [1:0]                   CH_ROT,
    input  logic [3:0]                   CH_GAIN,
    input  logic [$clog2(MAX_DELAY)-1:0] CH_DELAY,
    input  logic [3:0]                   CH_NOISE_AMP,
    input  logic signed [DW-1:0]         CH_DC,
    input  logic [15:0]                  CH_SEED,
    input  logic                         SAT_CLR,
    output logic signed [DW-1:0]         ADC_I,
    output logic signed [DW-1:0]         ADC_Q,
    output logic                         ADC_vld,
    output logic                         SAT_FLAG
);

    localparam int AW = $clog2(MAX_DELAY);
    // Gain intermediate: DW+1 rotated value times a 4-bit gain fits in DW+6.
    localparam int GW = DW + 6;
    // Sum width: this adds headroom for the gained value, the noise and the DC term.
    localparam int SW = DW + 8;
    localparam logic [15:0]          DEF_SEED = 16'hACE1;
    localparam logic [3:0]           AMP_MAX  = 4'(NOISE_W);
    localparam logic signed [SW-1:0] SMAX     = {{(SW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [SW-1:0] SMIN     = ~SMAX;

    typedef struct packed {
        logic                 vld;
        logic signed [DW-1:0] i;
        logic signed [DW-1:0] q;
    } smp_t;

    // Sign-extend to DW+1 so that negating the most negative code cannot wrap.
    function automatic logic signed [DW:0] sext1(input logic signed [DW-1:0] x);
        return {x[DW-1], x};
    endfunction

    // Centred noise: (slice & m) - (m >> 1).
    function automatic logic signed [NOISE_W+1:0] noise(input logic [NOISE_W-1:0] sl,
                                                        input logic [NOISE_W:0]   m);
        logic [NOISE_W:0] a;
        a = {1'b0, sl} & m;
        return $signed({1'b0, a}) - $signed({1'b0, m >> 1});
    endfunction

    // ---------------- state ----------------
    smp_t                  mem_q [MAX_DELAY];
    logic [AW-1:0]         wp_q, wp_d;
    smp_t                  s0_q, s0_d;
    logic                  s1_vld_q, s1_vld_d;
    logic signed [GW-1:0]  s1_i_q, s1_i_d;
    logic signed [GW-1:0]  s1_q_q, s1_q_d;
    logic signed [DW-1:0]  adc_i_q, adc_i_d;
    logic signed [DW-1:0]  adc_q_q, adc_q_d;
    logic                  adc_vld_q, adc_vld_d;
    logic                  sat_q, sat_d;
    logic [15:0]           lfsr_q, lfsr_d;

    // ---------------- S0: delay-line read ----------------
    smp_t          in_smp;
    smp_t          rd_smp;
    logic [AW-1:0] rd_idx;

    assign in_smp = {DAC_vld, DAC_I, DAC_Q};

    always_comb begin
        wp_d   = wp_q + 1'b1;
        rd_idx = wp_q - CH_DELAY;
        // The slot at wp is overwritten this cycle. Zero delay therefore means the
        // incoming sample itself, which keeps the minimum latency at 3.
        if (CH_DELAY == '0) begin
            rd_smp = in_smp;
        end else begin
            rd_smp = mem_q[rd_idx];
        end
        s0_d = rd_smp;
    end

    // ---------------- S1: rotate + gain ----------------
    logic signed [DW:0]   rot_i, rot_q;
    logic signed [GW-1:0] rot_i_x, rot_q_x, gain_x, prod_i, prod_q;

    always_comb begin
        case (CH_ROT)
            2'd0: begin
                rot_i = sext1(s0_q.i);
                rot_q = sext1(s0_q.q);
            end
            2'd1: begin
                rot_i = sext1(s0_q.q);
                rot_q = -sext1(s0_q.i);
            end
            2'd2: begin
                rot_i = -sext1(s0_q.i);
                rot_q = -sext1(s0_q.q);
            end
            default: begin
                rot_i = -sext1(s0_q.q);
                rot_q = sext1(s0_q.i);
            end
        endcase
        rot_i_x  = {{(GW-DW-1){rot_i[DW]}}, rot_i};
        rot_q_x  = {{(GW-DW-1){rot_q[DW]}}, rot_q};
        gain_x   = {{(GW-4){1'b0}}, CH_GAIN};
        prod_i   = rot_i_x * gain_x;
        prod_q   = rot_q_x * gain_x;
        // An arithmetic shift floors toward minus infinity.
        s1_i_d   = prod_i >>> 2;
        s1_q_d   = prod_q >>> 2;
        s1_vld_d = s0_q.vld;
    end

    // ---------------- S2: noise + DC + saturate ----------------
    logic [3:0]                amp_c;
    logic [NOISE_W:0]          mask;
    logic signed [NOISE_W+1:0] n_i, n_q;
    logic signed [SW-1:0]      sum_i, sum_q;
    logic                      hi_i, lo_i, hi_q, lo_q;

    always_comb begin
        amp_c = (CH_NOISE_AMP > AMP_MAX) ? AMP_MAX : CH_NOISE_AMP;
        mask  = ({{NOISE_W{1'b0}}, 1'b1} << amp_c) - {{NOISE_W{1'b0}}, 1'b1};
        n_i   = noise(lfsr_q[NOISE_W-1:0], mask);
        n_q   = noise(lfsr_q[15 -: NOISE_W], mask);

        sum_i = {{(SW-GW){s1_i_q[GW-1]}}, s1_i_q}
              + {{(SW-NOISE_W-2){n_i[NOISE_W+1]}}, n_i}
              + {{(SW-DW){CH_DC[DW-1]}}, CH_DC};
        sum_q = {{(SW-GW){s1_q_q[GW-1]}}, s1_q_q}
              + {{(SW-NOISE_W-2){n_q[NOISE_W+1]}}, n_q}
              + {{(SW-DW){CH_DC[DW-1]}}, CH_DC};

        hi_i = sum_i > SMAX;
        lo_i = sum_i < SMIN;
        hi_q = sum_q > SMAX;
        lo_q = sum_q < SMIN;

        adc_vld_d = s1_vld_q;
        adc_i_d   = '0;
        adc_q_d   = '0;
        sat_d     = sat_q;
        if (s1_vld_q) begin
            adc_i_d = hi_i ? SMAX[DW-1:0] : (lo_i ? SMIN[DW-1:0] : sum_i[DW-1:0]);
            adc_q_d = hi_q ? SMAX[DW-1:0] : (lo_q ? SMIN[DW-1:0] : sum_q[DW-1:0]);
        end
        // If a clip and SAT_CLR arrive together, the clip wins so the event is not lost.
        if (s1_vld_q && (hi_i || lo_i || hi_q || lo_q)) begin
            sat_d = 1'b1;
        end else if (SAT_CLR) begin
            sat_d = 1'b0;
        end

        // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right. It runs every cycle.
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_16M384) begin
        if (rst_16M384) begin
            for (int k = 0; k < MAX_DELAY; k++) begin
                mem_q[k] <= '0;
            end
            wp_q      <= '0;
            s0_q      <= '0;
            s1_vld_q  <= 1'b0;
            s1_i_q    <= '0;
            s1_q_q    <= '0;
            adc_i_q   <= '0;
            adc_q_q   <= '0;
            adc_vld_q <= 1'b0;
            sat_q     <= 1'b0;
            lfsr_q    <= (CH_SEED == 16'd0) ? DEF_SEED : CH_SEED;
        end else begin
            mem_q[wp_q] <= in_smp;
            wp_q        <= wp_d;
            s0_q        <= s0_d;
            s1_vld_q    <= s1_vld_d;
            s1_i_q      <= s1_i_d;
            s1_q_q      <= s1_q_d;
            adc_i_q     <= adc_i_d;
            adc_q_q     <= adc_q_d;
            adc_vld_q   <= adc_vld_d;
            sat_q       <= sat_d;
            lfsr_q      <= lfsr_d;
        end
    end

    assign ADC_I    = adc_i_q;
    assign ADC_Q    = adc_q_q;
    assign ADC_vld  = adc_vld_q;
    assign SAT_FLAG = sat_q;

endmodule

// File: tb/tb_loopback_channel.sv
module tb_loopback_channel;

    localparam int DW = 12;
    localparam int MD = 16;
    localparam int NW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic signed [DW-1:0] dac_i, dac_q;
    logic                 dac_vld;
    logic [1:0]           rot;
    logic [3:0]           gain;
    logic [3:0]           dly;
    logic [3:0]           amp;
    logic signed [DW-1:0] dc;
    logic [15:0]          seed;
    logic                 sat_clr;
    logic signed [DW-1:0] adc_i, adc_q;
    logic                 adc_vld, sat_flag;

    loopback_channel #(.DW(DW), .MAX_DELAY(MD), .NOISE_W(NW)) dut (
        .clk_16M384   (clk),
        .rst_16M384   (rst),
        .DAC_I        (dac_i),
        .DAC_Q        (dac_q),
        .DAC_vld      (dac_vld),
        .CH_ROT       (rot),
        .CH_GAIN      (gain),
        .CH_DELAY     (dly),
        .CH_NOISE_AMP (amp),
        .CH_DC        (dc),
        .CH_SEED      (seed),
        .SAT_CLR      (sat_clr),
        .ADC_I        (adc_i),
        .ADC_Q        (adc_q),
        .ADC_vld      (adc_vld),
        .SAT_FLAG     (sat_flag)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // ---------------- behavioural model ----------------
    // The model keeps a history of accepted input samples indexed by clock edge.
    // The output after edge k is the sample accepted at edge k-2-delay, if that
    // edge came after the last reset.
    int          edge_n   = 0;
    int          last_rst = 0;
    bit          hv [64];
    int          hi [64];
    int          hq [64];
    logic [15:0] m_lfsr;
    int          e_i = 0, e_q = 0;
    bit          e_v = 0, e_s = 0;

    function automatic int noise_of(int slice, int a_in);
        int a, m;
        a = (a_in > NW) ? NW : a_in;
        m = (1 << a) - 1;
        return (slice & m) - (m >> 1);
    endfunction

    function automatic int rail(int x, int g, int n, int d, output bit clip);
        int s;
        s = ((x * g) >>> 2) + n + d;
        clip = 1'b0;
        if (s > 2047) begin
            s = 2047;
            clip = 1'b1;
        end else if (s < -2048) begin
            s = -2048;
            clip = 1'b1;
        end
        return s;
    endfunction

    always @(posedge clk) begin
        int src, xi, xq, ri, rq;
        bit ci, cq;
        edge_n++;
        if (rst) begin
            last_rst = edge_n;
            e_i = 0; e_q = 0; e_v = 0; e_s = 0;
            m_lfsr = (seed == 16'd0) ? 16'hACE1 : seed;
        end else begin
            hv[edge_n % 64] = dac_vld;
            hi[edge_n % 64] = int'(dac_i);
            hq[edge_n % 64] = int'(dac_q);
            src = edge_n - 2 - int'(dly);
            if (src > last_rst && hv[src % 64]) begin
                xi = hi[src % 64];
                xq = hq[src % 64];
                case (rot)
                    2'd0: begin ri = xi;  rq = xq;  end
                    2'd1: begin ri = xq;  rq = -xi; end
                    2'd2: begin ri = -xi; rq = -xq; end
                    default: begin ri = -xq; rq = xi; end
                endcase
                e_i = rail(ri, int'(gain), noise_of(int'(m_lfsr[NW-1:0]), int'(amp)), int'(dc), ci);
                e_q = rail(rq, int'(gain), noise_of(int'(m_lfsr[15 -: NW]), int'(amp)), int'(dc), cq);
                e_v = 1'b1;
                if (ci || cq) e_s = 1'b1;
                else if (sat_clr) e_s = 1'b0;
            end else begin
                e_i = 0; e_q = 0; e_v = 1'b0;
                if (sat_clr) e_s = 1'b0;
            end
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
        end
    end

    // Compare the DUT with the model on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            n_cmp++;
            if ($isunknown({adc_i, adc_q, adc_vld, sat_flag}) ||
                int'(adc_i) != e_i || int'(adc_q) != e_q ||
                adc_vld != e_v || sat_flag != e_s) begin
                n_bad++;
                $display("FAIL model t=%0t: got I=%0d Q=%0d vld=%0b sat=%0b, want I=%0d Q=%0d vld=%0b sat=%0b",
                         $time, adc_i, adc_q, adc_vld, sat_flag, e_i, e_q, e_v, e_s);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic idle(input int n);
        dac_vld = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send(input int i, input int q);
        dac_vld = 1'b1;
        dac_i = DW'(i);
        dac_q = DW'(q);
        tick();
        dac_vld = 1'b0;
    endtask

    task automatic rand_smp();
        dac_vld = 1'b1;
        dac_i = DW'($urandom);
        dac_q = DW'($urandom);
    endtask

    task automatic pulse_lat(input string nm, input int exp_lat);
        int k;
        rand_smp();
        tick();
        dac_vld = 1'b0;
        k = 1;
        while (!adc_vld && k < 40) begin
            tick();
            k++;
        end
        chk({nm, "_latency"}, k, exp_lat);
        tick();
        chk({nm, "_width"}, int'(adc_vld), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion, want finish before timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int v_rot [5] = '{2, 3, 0, 1, 0};
    int v_gn  [5] = '{4, 1, 1, 15, 0};
    int v_dc  [5] = '{0, 0, 0, -2048, 300};
    int v_i   [5] = '{-2048, 7, -5, 100, 1000};
    int v_q   [5] = '{5, -9, -1, -100, -1000};
    int x_i   [5] = '{2047, 2, -2, -2048, 300};
    int x_q   [5] = '{-5, 1, -1, -2048, 300};
    int seq_i [1000];
    int seq_q [1000];

    initial begin
        int nz, cnt, oor, rep, f_i, f_q, lows;
        rst = 1'b1; dac_vld = 1'b0; dac_i = '0; dac_q = '0;
        rot = 2'd0; gain = 4'd4; dly = 4'd0; amp = 4'd0; dc = '0;
        seed = 16'h1234; sat_clr = 1'b0;
        tick(); tick();
        chk("reset_adc_i", int'(adc_i), 0);
        chk("reset_adc_q", int'(adc_q), 0);
        chk("reset_vld", int'(adc_vld), 0);
        chk("reset_sat", int'(sat_flag), 0);
        rst = 1'b0;
        chk_en = 1'b1;
        idle(4);

        // Rotate 90 degrees, gain 3/4, DC -16.
        rot = 2'd1; gain = 4'd3; amp = 4'd0; dc = -12'sd16;
        send(400, 100);
        tick(); tick();
        chk("rot90_vld", int'(adc_vld), 1);
        chk("rot90_i", int'(adc_i), 59);
        chk("rot90_q", int'(adc_q), -316);
        tick();
        chk("rot90_vld_drop", int'(adc_vld), 0);
        chk("rot90_no_sat", int'(sat_flag), 0);
        idle(20);

        // Saturation and sticky flag.
        rot = 2'd0; gain = 4'd8; dc = '0;
        send(2047, -2048);
        tick(); tick();
        chk("clip_i", int'(adc_i), 2047);
        chk("clip_q", int'(adc_q), -2048);
        chk("clip_sat", int'(sat_flag), 1);
        tick(); tick(); tick();
        chk("sat_held", int'(sat_flag), 1);
        sat_clr = 1'b1;
        tick();
        sat_clr = 1'b0;
        chk("sat_cleared", int'(sat_flag), 0);
        idle(4);
        // A clip that coincides with SAT_CLR sets the flag, and the next clear drops it.
        sat_clr = 1'b1;
        send(2047, 0);
        tick(); tick();
        chk("setwins_sat", int'(sat_flag), 1);
        tick();
        chk("setwins_then_clr", int'(sat_flag), 0);
        sat_clr = 1'b0;
        idle(20);

        // Directed rotation/gain/DC vectors.
        for (int k = 0; k < 5; k++) begin
            rot = 2'(v_rot[k]); gain = 4'(v_gn[k]); dc = DW'(v_dc[k]);
            send(v_i[k], v_q[k]);
            tick(); tick();
            chk($sformatf("vec%0d_i", k), int'(adc_i), x_i[k]);
            chk($sformatf("vec%0d_q", k), int'(adc_q), x_q[k]);
            idle(20);
        end

        // Delay-line latency.
        rot = 2'd0; gain = 4'd4; dc = '0; amp = 4'd2;
        dly = 4'd5;
        idle(20);
        pulse_lat("delay5", 8);
        idle(20);
        dly = 4'd15;
        idle(20);
        pulse_lat("delay15", 18);
        idle(20);
        dly = 4'd0;
        idle(20);

        // Idle channel with DC and noise configured.
        dc = 12'sd100; amp = 4'd4;
        nz = 0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (adc_i != 0 || adc_q != 0 || adc_vld != 0) nz++;
        end
        chk("idle_outputs_zero", nz, 0);

        // Noise-only stream from seed 16'h1234, run twice.
        rot = 2'd0; gain = 4'd4; dc = '0; amp = 4'd4; dly = 4'd0; seed = 16'h1234;
        f_i = 0; f_q = 0; oor = 0; rep = 0;
        for (int run = 0; run < 2; run++) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            dac_vld = 1'b1; dac_i = '0; dac_q = '0;
            cnt = 0;
            for (int c = 0; c < 1002; c++) begin
                tick();
                if (adc_vld && cnt < 1000) begin
                    if (run == 0) begin
                        seq_i[cnt] = int'(adc_i);
                        seq_q[cnt] = int'(adc_q);
                        if (cnt == 0) begin
                            f_i = int'(adc_i);
                            f_q = int'(adc_q);
                        end
                    end else if (seq_i[cnt] != int'(adc_i) || seq_q[cnt] != int'(adc_q)) begin
                        rep++;
                    end
                    if (adc_i < -7 || adc_i > 8 || adc_q < -7 || adc_q > 8) oor++;
                    cnt++;
                end
            end
            chk($sformatf("noise_count_run%0d", run), cnt, 1000);
        end
        dac_vld = 1'b0;
        chk("noise_first_i", f_i, 6);
        chk("noise_first_q", f_q, -3);
        chk("noise_out_of_range", oor, 0);
        chk("noise_repeat_mismatches", rep, 0);
        idle(4);

        // A zero seed selects the default seed 16'hACE1.
        seed = 16'h0000;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dac_vld = 1'b1; dac_i = '0; dac_q = '0;
        tick(); dac_vld = 1'b0;
        tick(); tick();
        chk("seed0_i", int'(adc_i), 1);
        chk("seed0_q", int'(adc_q), 4);
        idle(20);

        // Reset pulse in the middle of a continuous stream.
        rot = 2'd3; gain = 4'd5; amp = 4'd12; dc = 12'sd5; dly = 4'd2; seed = 16'hBEEF;
        for (int c = 0; c < 30; c++) begin
            rand_smp();
            tick();
        end
        rst = 1'b1;
        rand_smp();
        tick();
        rst = 1'b0;
        chk("midrst_i", int'(adc_i), 0);
        chk("midrst_q", int'(adc_q), 0);
        lows = 0;
        while (!adc_vld && lows < 40) begin
            lows++;
            rand_smp();
            tick();
        end
        chk("midrst_low_cycles", lows, 5);
        for (int c = 0; c < 20; c++) begin
            rand_smp();
            tick();
        end
        idle(20);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
